// File: rtl/dp_ram_fifo_if.sv
// Handshake and RAM-port bundle for dp_ram_fifo.
// The slave side is the FIFO. The master side is the producer/consumer/RAM environment.
interface dp_ram_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  push_valid;
    logic                  push_ready;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop_valid;
    logic                  pop_ready;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  ram_wr_en;
    logic [31:0]           ram_wr_addr;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic                  ram_rd_en;
    logic [31:0]           ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    modport slave (
        input  push_valid, push_data, pop_ready, ram_rd_data,
        output push_ready, pop_valid, pop_data,
               ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr
    );

    modport master (
        output push_valid, push_data, pop_ready, ram_rd_data,
        input  push_ready, pop_valid, pop_data,
               ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr
    );
endinterface

// File: rtl/dp_ram_fifo.sv
// Show-ahead FIFO controller whose storage is an external RAM.
// The RAM has a synchronous write port and an asynchronous read port.
module dp_ram_fifo #(
    parameter int          DATA_WIDTH = 8,
    parameter int          ADDR_WIDTH = 3,
    parameter logic [31:0] BASE_ADDR  = 32'd0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    dp_ram_fifo_if.slave        bus,
    output logic [ADDR_WIDTH:0] count
);
    logic [ADDR_WIDTH:0] r_wr_ptr;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    logic [ADDR_WIDTH:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    // The MSB of each pointer is a wrap bit. Equal low bits with different
    // wrap bits means the write side has lapped the read side.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                     (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);

    // Handshakes are suppressed while reset or flush is asserted, so the RAM is never written then.
    assign w_push = bus.push_valid && !w_full  && !flush && !rst;
    assign w_pop  = bus.pop_ready  && !w_empty && !flush && !rst;

    assign bus.push_ready  = !w_full;
    assign bus.pop_valid   = !w_empty;

    assign bus.ram_wr_en   = w_push;
    assign bus.ram_wr_addr = BASE_ADDR + 32'(r_wr_ptr[ADDR_WIDTH-1:0]);
    assign bus.ram_wr_data = bus.push_data;

    assign bus.ram_rd_en   = !w_empty;
    assign bus.ram_rd_addr = BASE_ADDR + 32'(r_rd_ptr[ADDR_WIDTH-1:0]);
    assign bus.pop_data    = w_empty ? '0 : bus.ram_rd_data;

    assign count = r_count;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_dp_ram_fifo.sv
// Directed bench for dp_ram_fifo with BASE_ADDR=16 and a behavioural RAM model.
module tb_dp_ram_fifo;
    localparam int          DW   = 8;
    localparam int          AW   = 3;
    localparam logic [31:0] BASE = 32'd16;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [AW:0]   count;
    logic [DW-1:0] mem [0:63];
    int            n_chk = 0;
    int            n_err = 0;
    logic [DW-1:0] q [$];

    dp_ram_fifo_if #(.DATA_WIDTH(DW)) bus ();

    dp_ram_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave),
        .count (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.ram_wr_en) mem[int'(bus.ram_wr_addr % 32'd64)] <= bus.ram_wr_data;
    assign bus.ram_rd_data = mem[int'(bus.ram_rd_addr % 32'd64)];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b0;
        flush          = 1'b0;
        rst            = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        chk("rst_wr_en", 32'(bus.ram_wr_en), 0);
        step();
        rst = 1'b0;
        #1;
        chk("rst_push_ready", 32'(bus.push_ready), 1);
        chk("rst_pop_valid", 32'(bus.pop_valid), 0);
        chk("rst_pop_data", 32'(bus.pop_data), 0);
        chk("rst_rd_en", 32'(bus.ram_rd_en), 0);
        chk("rst_count", 32'(count), 0);
    endtask

    // Push one entry and check the RAM write strobe in the same cycle.
    task automatic push(input logic [DW-1:0] d, input logic [31:0] exp_addr);
        bus.push_valid = 1'b1;
        bus.push_data  = d;
        #1;
        chk("push_wr_en", 32'(bus.ram_wr_en), 1);
        chk("push_wr_addr", bus.ram_wr_addr, exp_addr);
        chk("push_wr_data", 32'(bus.ram_wr_data), 32'(d));
        step();
        bus.push_valid = 1'b0;
    endtask

    task automatic pop(input logic [DW-1:0] exp);
        bus.pop_ready = 1'b1;
        #1;
        chk("pop_valid", 32'(bus.pop_valid), 1);
        chk("pop_data", 32'(bus.pop_data), 32'(exp));
        step();
        bus.pop_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        bus.push_data = '0;
        idle();

        // Single push: one-cycle latency with no bypass into an empty FIFO.
        do_reset();
        bus.push_valid = 1'b1;
        bus.push_data  = 8'hA5;
        #1;
        chk("a5_wr_en", 32'(bus.ram_wr_en), 1);
        chk("a5_wr_addr", bus.ram_wr_addr, BASE);
        chk("a5_no_bypass", 32'(bus.pop_valid), 0);
        step();
        bus.push_valid = 1'b0;
        #1;
        chk("a5_wr_en_off", 32'(bus.ram_wr_en), 0);
        chk("a5_pop_valid", 32'(bus.pop_valid), 1);
        chk("a5_pop_data", 32'(bus.pop_data), 32'hA5);
        chk("a5_count", 32'(count), 1);
        chk("a5_rd_addr", bus.ram_rd_addr, BASE);

        // Fill to full, refuse a ninth push, then drain in order.
        do_reset();
        for (int i = 0; i < 8; i++) push(8'(i + 1), BASE + 32'(i));
        chk("full_push_ready", 32'(bus.push_ready), 0);
        chk("full_count", 32'(count), 8);
        bus.push_valid = 1'b1;
        bus.push_data  = 8'h99;
        #1;
        chk("full_no_wr", 32'(bus.ram_wr_en), 0);
        step();
        bus.push_valid = 1'b0;
        chk("full_count2", 32'(count), 8);
        for (int i = 0; i < 8; i++) pop(8'(i + 1));
        chk("drain_pop_valid", 32'(bus.pop_valid), 0);
        chk("drain_count", 32'(count), 0);
        chk("drain_pop_data", 32'(bus.pop_data), 0);
        bus.pop_ready = 1'b1;
        step();
        bus.pop_ready = 1'b0;
        chk("empty_pop_ignored", 32'(count), 0);
        chk("empty_rd_addr", bus.ram_rd_addr, BASE);

        // Address wrap: 6 in, 6 out, then 4 more land at 6, 7, 0, 1.
        do_reset();
        for (int i = 0; i < 6; i++) push(8'(8'h40 + i), BASE + 32'(i));
        for (int i = 0; i < 6; i++) pop(8'(8'h40 + i));
        push(8'h10, BASE + 32'd6);
        push(8'h11, BASE + 32'd7);
        push(8'h12, BASE + 32'd0);
        push(8'h13, BASE + 32'd1);
        for (int i = 0; i < 4; i++) pop(8'(8'h10 + i));
        chk("wrap_count", 32'(count), 0);

        // Streaming at count=3, then a push+pop into a full FIFO.
        do_reset();
        q.delete();
        for (int i = 0; i < 3; i++) begin
            push(8'(8'h20 + i), BASE + 32'(i));
            q.push_back(8'(8'h20 + i));
        end
        for (int i = 0; i < 20; i++) begin
            bus.push_valid = 1'b1;
            bus.push_data  = 8'(8'h30 + i);
            bus.pop_ready  = 1'b1;
            #1;
            chk("stream_data", 32'(bus.pop_data), 32'(q[0]));
            chk("stream_wr_addr", bus.ram_wr_addr, BASE + 32'((i + 3) % 8));
            step();
            void'(q.pop_front());
            q.push_back(8'(8'h30 + i));
            chk("stream_count", 32'(count), 3);
        end
        idle();
        for (int i = 0; i < 5; i++) begin
            push(8'(8'h50 + i), BASE + 32'((23 + i) % 8));
            q.push_back(8'(8'h50 + i));
        end
        chk("stream_full", 32'(count), 8);
        bus.push_valid = 1'b1;
        bus.push_data  = 8'hEE;
        bus.pop_ready  = 1'b1;
        #1;
        chk("full_pp_no_wr", 32'(bus.ram_wr_en), 0);
        chk("full_pp_data", 32'(bus.pop_data), 32'(q[0]));
        step();
        idle();
        void'(q.pop_front());
        chk("full_pp_count", 32'(count), 7);
        chk("full_pp_ready", 32'(bus.push_ready), 1);
        for (int i = 0; i < 7; i++) pop(q[i]);

        // Flush with a push pending, then recover.
        do_reset();
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i), BASE + 32'(i));
        flush          = 1'b1;
        bus.push_valid = 1'b1;
        bus.push_data  = 8'hBB;
        bus.pop_ready  = 1'b1;
        #1;
        chk("flush_no_wr", 32'(bus.ram_wr_en), 0);
        step();
        idle();
        chk("flush_count", 32'(count), 0);
        chk("flush_pop_valid", 32'(bus.pop_valid), 0);
        push(8'h77, BASE);
        pop(8'h77);

        // Reset mid-stream with a push pending discards everything.
        for (int i = 0; i < 3; i++) push(8'(8'h80 + i), BASE + 32'(i + 1));
        rst            = 1'b1;
        bus.push_valid = 1'b1;
        bus.push_data  = 8'hCC;
        #1;
        chk("rst_mid_no_wr", 32'(bus.ram_wr_en), 0);
        step();
        idle();
        chk("rst_mid_count", 32'(count), 0);
        chk("rst_mid_pop_valid", 32'(bus.pop_valid), 0);
        push(8'h5A, BASE);
        pop(8'h5A);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dp_ram_fifo.md
DP_RAM_FIFO -- requirements
Module: dp_ram_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of each FIFO entry and of the RAM data ports.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3: FIFO depth is 2**ADDR_WIDTH entries.
REQ-003 SHALL have parameter BASE_ADDR, default 0: RAM address of FIFO entry 0.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port flush, input, 1: synchronous clear of FIFO occupancy.
REQ-007 SHALL have port push_valid, input, 1: the producer offers push_data.
REQ-008 SHALL have port push_ready, output, 1: the FIFO can accept an entry.
REQ-009 SHALL have port push_data, input, DATA_WIDTH: the entry to store.
REQ-010 SHALL have port pop_valid, output, 1: the FIFO holds at least one entry.
REQ-011 SHALL have port pop_ready, input, 1: the consumer takes pop_data.
REQ-012 SHALL have port pop_data, output, DATA_WIDTH: the oldest entry (show-ahead).
REQ-013 SHALL have port count, output, ADDR_WIDTH+1: the current occupancy.
REQ-014 SHALL have ports ram_wr_en (output, 1), ram_wr_addr (output, 32) and ram_wr_data (output, DATA_WIDTH): drive the RAM synchronous write port.
REQ-015 SHALL have ports ram_rd_en (output, 1), ram_rd_addr (output, 32) and ram_rd_data (input, DATA_WIDTH): drive the RAM asynchronous read port.

Function
REQ-016 SHALL hold wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits; the MSB is a wrap bit.
REQ-017 SHALL define empty as wr_ptr == rd_ptr.
REQ-018 SHALL define full as low ADDR_WIDTH bits equal and MSBs different.
REQ-019 SHALL drive push_ready = !full and pop_valid = !empty, both combinationally from registered pointers only.
REQ-020 SHALL define a push as push_valid && push_ready, and a pop as pop_valid && pop_ready.
REQ-021 SHALL, on a push, drive ram_wr_en=1, ram_wr_addr=BASE_ADDR+wr_ptr[ADDR_WIDTH-1:0] and ram_wr_data=push_data in the same cycle, and increment wr_ptr at the clock edge.
REQ-022 SHALL drive ram_wr_en=0 in every cycle without a push.
REQ-023 SHALL drive ram_rd_en = pop_valid and ram_rd_addr = BASE_ADDR+rd_ptr[ADDR_WIDTH-1:0] continuously.
REQ-024 SHALL drive pop_data = ram_rd_data when pop_valid=1, otherwise 0.
REQ-025 SHALL increment rd_ptr at the clock edge on a pop.
REQ-026 SHALL make a pushed entry visible on pop_data the cycle after the push: latency 1, with no same-cycle bypass when empty.
REQ-027 SHALL perform both operations on a simultaneous push and pop when 0<count<depth, leaving count unchanged.
REQ-028 SHALL refuse a push when full (push_ready=0) even if a pop occurs in the same cycle.
REQ-029 SHALL ignore pop_ready when empty.
REQ-030 SHALL have pointers wrap modulo 2**(ADDR_WIDTH+1), so RAM addresses wrap from BASE_ADDR+depth-1 to BASE_ADDR.
REQ-031 SHALL register count, updating it +1 on push only, -1 on pop only, and leaving it unchanged on both or neither.
REQ-032 SHALL, on flush=1, set both pointers and count to 0 at the clock edge, ignoring any push/pop in that cycle; ram_wr_en SHALL be 0 during flush.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, set wr_ptr=0, rd_ptr=0 and count=0.
REQ-034 SHALL output push_ready=1, pop_valid=0, pop_data=0, ram_wr_en=0 and ram_rd_en=0 while rst=1 and in the first cycle after reset.
REQ-035 SHALL give rst priority over flush, push and pop; RAM contents are not cleared, and a reset mid-stream discards all entries.

Verification
REQ-036 Reset then push 0xA5 -> next cycle pop_valid=1, pop_data=0xA5, count=1, ram_wr_addr was BASE_ADDR+0 with ram_wr_en=1 for one cycle.
REQ-037 Push 8 entries 0x01..0x08 (ADDR_WIDTH=3) -> push_ready=0, count=8; 9th push ignored (no ram_wr_en); pops return 0x01..0x08 in order, then pop_valid=0.
REQ-038 Wrap: push 6, pop 6, push 4 (0x10..0x13) -> writes to addresses BASE+6, 7, 0, 1; pops return 0x10..0x13; count ends 0.
REQ-039 Continuous push+pop at count=3 for 20 cycles -> count stays 3, data order preserved; when full, push+pop -> only the pop occurs, count=7.
REQ-040 Push 5, assert flush (or rst) with push_valid=1 -> next cycle count=0, pop_valid=0, no RAM write in flush cycle; a subsequent push reads back correctly.
